// File: rtl/prng_lane_add_seq.sv
// Segmented 256-bit add/subtract that time-shares one 33-bit adder over eight 32-bit lanes.
// Carries chain only inside a segment; lane 0 is written on the first cycle after the accept.
module prng_lane_add_seq #(
    parameter int LANE_W  = 32,
    parameter int N_LANES = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [LANE_W*N_LANES-1:0]   a_i,
    input  logic [LANE_W*N_LANES-1:0]   b_i,
    input  logic [2:0]                  width_i,
    input  logic                        sub_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANE_W*N_LANES-1:0]   sum_o,
    output logic [N_LANES-1:0]          seg_carry_o
);

    localparam int CNT_W = $clog2(N_LANES);

    typedef logic [LANE_W*N_LANES-1:0] prng_t;
    typedef logic [2:0]                width_t;
    typedef struct packed {
        logic              carry;
        logic [LANE_W-1:0] val;
    } u32_w_c_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Bit 32k set means lane k starts a new segment. width bit 2 fuses lane pairs,
    // bit 1 fuses pairs into quads, bit 0 fuses the two quads.
    function automatic prng_t make_carry_mask(input width_t w);
        prng_t m;
        logic  fused;
        m = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (k == 0)          fused = 1'b0;
            else if (k % 2 == 1) fused = w[2];
            else if (k % 4 == 2) fused = w[1];
            else                 fused = w[0];
            m[LANE_W*k] = ~fused;
        end
        return m;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    lane_q, lane_d;
    prng_t               a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                sub_q, sub_d, carry_q, carry_d;
    logic [N_LANES-1:0]  seg_start_q, seg_start_d, seg_carry_q, seg_carry_d;

    prng_t               mask_in;
    logic [LANE_W-1:0]   b_lane;
    logic                cin, seg_top;
    u32_w_c_t            res;

    always_comb begin
        mask_in = make_carry_mask(width_i);
        b_lane  = sub_q ? ~b_q[LANE_W*lane_q +: LANE_W] : b_q[LANE_W*lane_q +: LANE_W];
        cin     = (lane_q == '0 || seg_start_q[lane_q]) ? sub_q : carry_q;
        res     = {1'b0, a_q[LANE_W*lane_q +: LANE_W]} + {1'b0, b_lane} + {{LANE_W{1'b0}}, cin};
        // lane_q+1 wraps to 0 on the last lane, whose start bit is always set
        seg_top = (lane_q == CNT_W'(N_LANES-1)) || seg_start_q[lane_q + 1'b1];
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        seg_start_d = seg_start_q;
        sum_d       = sum_q;
        seg_carry_d = seg_carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d         = a_i;
                    b_d         = b_i;
                    sub_d       = sub_i;
                    for (int k = 0; k < N_LANES; k++) seg_start_d[k] = mask_in[LANE_W*k];
                    lane_d      = '0;
                    carry_d     = 1'b0;
                    sum_d       = '0;
                    seg_carry_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                sum_d[LANE_W*lane_q +: LANE_W] = res.val;
                carry_d                        = res.carry;
                seg_carry_d[lane_q]            = seg_top & res.carry;
                lane_d                         = lane_q + 1'b1;
                if (lane_q == CNT_W'(N_LANES-1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            seg_start_q <= '0;
            sum_q       <= '0;
            seg_carry_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            seg_start_q <= seg_start_d;
            sum_q       <= sum_d;
            seg_carry_q <= seg_carry_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign sum_o       = sum_q;
    assign seg_carry_o = seg_carry_q;

endmodule

// File: tb/tb_prng_lane_add_seq.sv
// Bench for prng_lane_add_seq: directed vector table, handshake/reset sequences,
// and random operations checked against a whole-segment arithmetic model.
module tb_prng_lane_add_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, sub;
    logic [255:0] a, b, sum;
    logic [2:0]   width;
    logic [7:0]   seg_carry;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    prng_lane_add_seq dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .width_i     (width),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .seg_carry_o (seg_carry)
    );

    typedef struct {
        string        name;
        logic [255:0] a;
        logic [255:0] b;
        logic [2:0]   w;
        logic         sub;
        logic [255:0] exp_sum;
        logic [7:0]   exp_carry;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: treat each segment as one wide unsigned number.
    function automatic void ref_op(input logic [255:0] ra, input logic [255:0] rb, input logic [2:0] w,
                                   input logic rsub, output logic [255:0] s, output logic [7:0] c);
        int           seg;
        logic [256:0] m, x, y, r;
        case (w)
            3'b000:  seg = 32;
            3'b100:  seg = 64;
            3'b110:  seg = 128;
            default: seg = 256;
        endcase
        m = (257'd1 << seg) - 257'd1;
        s = '0;
        c = '0;
        for (int lo = 0; lo < 256; lo += seg) begin
            x = ({1'b0, ra} >> lo) & m;
            y = ({1'b0, rb} >> lo) & m;
            if (rsub) begin
                c[(lo + seg) / 32 - 1] = (x >= y);
                r = (x - y) & m;
            end else begin
                r = x + y;
                c[(lo + seg) / 32 - 1] = r[seg];
                r = r & m;
            end
            s = s | 256'(r << lo);
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) v[32*i +: 32] = 32'hFFFF_FFFF;
            else                           v[32*i +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic accept_op(input logic [255:0] ta, input logic [255:0] tb, input logic [2:0] tw,
                             input logic tsub);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("ready_before_accept", {255'b0, in_ready}, 256'd1);
        a = ta; b = tb; width = tw; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = rand256(); b = rand256(); width = 3'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_valid(input string name);
        int lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 30);
        chk({name, "_latency"}, 256'(lat), 256'd8);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [255:0] ta, input logic [255:0] tb,
                          input logic [2:0] tw, input logic tsub,
                          input logic [255:0] es, input logic [7:0] ec);
        accept_op(ta, tb, tw, tsub);
        chk({name, "_ready_low"}, {255'b0, in_ready}, 256'd0);
        wait_valid(name);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        chk({name, "_sum"}, sum, es);
        chk({name, "_carry"}, {248'b0, seg_carry}, {248'b0, ec});
        handshake();
        chk({name, "_valid_drop"}, {255'b0, out_valid}, 256'd0);
    endtask

    initial begin
        vec_t         vecs[6];
        logic [255:0] r, es, held;
        logic [7:0]   ec;
        logic [255:0] ra, rb;
        logic [2:0]   rw;
        logic         rs;
        logic [2:0]   widths[4];

        widths[0] = 3'b000; widths[1] = 3'b100; widths[2] = 3'b110; widths[3] = 3'b111;
        r = rand256();
        vecs[0] = '{"add32", {8{32'hFFFF_FFFF}}, {8{32'h1}}, 3'b000, 1'b0, 256'd0, 8'hFF};
        vecs[1] = '{"add256", {256{1'b1}}, 256'd1, 3'b111, 1'b0, 256'd0, 8'h80};
        vecs[2] = '{"add64", {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF},
                   {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h1}, 3'b100, 1'b0,
                   {32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0}, 8'h00};
        vecs[3] = '{"sub256", 256'd0, 256'd1, 3'b111, 1'b1, {256{1'b1}}, 8'h00};
        vecs[4] = '{"sub128_eq", r, r, 3'b110, 1'b1, 256'd0, 8'h88};
        vecs[5] = '{"sub32_borrow", {8{32'h5}}, {8{32'h7}}, 3'b000, 1'b1, {8{32'hFFFF_FFFE}}, 8'h00};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; width = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {255'b0, in_ready}, 256'd1);
        chk("rst_valid", {255'b0, out_valid}, 256'd0);
        chk("rst_sum", sum, 256'd0);
        chk("rst_carry", {248'b0, seg_carry}, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].sub,
                   vecs[i].exp_sum, vecs[i].exp_carry);

        // Backpressure while in_valid pulses: nothing new may be taken or queued.
        ra = rand256(); rb = rand256();
        ref_op(ra, rb, 3'b100, 1'b0, es, ec);
        accept_op(ra, rb, 3'b100, 1'b0);
        wait_valid("bp");
        held = sum;
        chk("bp_sum", held, es);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = rand256(); b = rand256();
            @(posedge clk); #1;
            chk("bp_ready_low", {255'b0, in_ready}, 256'd0);
            chk("bp_valid_high", {255'b0, out_valid}, 256'd1);
            chk("bp_sum_stable", sum, es);
            chk("bp_carry_stable", {248'b0, seg_carry}, {248'b0, ec});
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_ready_after", {255'b0, in_ready}, 256'd1);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_no_queued", {254'b0, out_valid, in_ready}, 256'd1);
        end

        // Reset in the middle of RUN, with lane 4 about to be written.
        accept_op(vecs[0].a, vecs[0].b, vecs[0].w, vecs[0].sub);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {255'b0, in_ready}, 256'd1);
        chk("mid_rst_valid", {255'b0, out_valid}, 256'd0);
        chk("mid_rst_sum", sum, 256'd0);
        chk("mid_rst_carry", {248'b0, seg_carry}, 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_add32", vecs[0].a, vecs[0].b, vecs[0].w, vecs[0].sub,
               vecs[0].exp_sum, vecs[0].exp_carry);

        for (int i = 0; i < 40; i++) begin
            ra = rand256();
            rb = ($urandom_range(0, 4) == 0) ? ra : rand256();
            rw = widths[$urandom_range(0, 3)];
            rs = 1'($urandom);
            ref_op(ra, rb, rw, rs, es, ec);
            run_op($sformatf("rand%0d_w%b_s%0d", i, rw, rs), ra, rb, rw, rs, es, ec);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
